// File: rtl/log2_frac_iter_if.sv
// Handshake bundle for the linear-to-log fraction converter: an input
// channel carrying the significand fraction and an output channel carrying
// the rounded log2 fraction.
interface log2_frac_iter_if #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 7
);
    logic                in_valid;
    logic                in_ready;
    logic [IN_BITS-1:0]  in_frac;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_BITS-1:0] out_log;

    modport master (
        output in_valid,
        output in_frac,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_log
    );

    modport slave (
        input  in_valid,
        input  in_frac,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_log
    );
endinterface

// File: rtl/log2_frac_iter.sv
// Iterative linear-to-log fraction converter. Treats in_frac as the
// significand 1 + f/2^IN_BITS and produces round(log2(.) * 2^OUT_BITS),
// one result bit per clock by repeated squaring of a working register x.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | waiting for in_valid, in_ready high
//   S_ITER | squaring x, one result bit per edge, OUT_BITS+1 edges total
//   S_DONE | out_valid high, out_log held until out_ready
module log2_frac_iter #(
    parameter int IN_BITS   = 8,
    parameter int OUT_BITS  = 7,
    parameter int WORK_BITS = 16
) (
    input  logic             clock,
    input  logic             resetn,
    log2_frac_iter_if.slave  bus
);
    // x carries one integer bit plus WORK_BITS fractional bits, range [1,2)
    localparam int XW = WORK_BITS + 1;
    localparam int SW = 2 * XW;
    localparam int RW = OUT_BITS + 1;
    localparam int CW = (OUT_BITS + 1 > 1) ? $clog2(OUT_BITS + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    state_t              state;
    logic [XW-1:0]       x;
    logic [RW-1:0]       res;
    logic [CW-1:0]       cnt;
    logic                in_ready_r;
    logic                out_valid_r;
    logic [OUT_BITS-1:0] out_log_r;

    logic [SW-1:0]       x_ext;
    logic [SW-1:0]       sq;
    logic                sq_ge2;
    logic [XW-1:0]       x_next;
    logic [RW-1:0]       res_next;
    logic [OUT_BITS:0]   rounded;
    logic [XW-1:0]       x_load;

    // Square x, renormalise into [1,2) and form the rounded result candidate
    always_comb begin
        x_ext    = SW'(x);
        sq       = x_ext * x_ext;
        // sq has 2 integer bits; its top bit set means sq >= 2
        sq_ge2   = sq[SW-1];
        x_next   = sq_ge2 ? XW'(sq >> (WORK_BITS + 1)) : XW'(sq >> WORK_BITS);
        res_next = {res[RW-2:0], sq_ge2};
        // Upper OUT_BITS are the log fraction, the last bit rounds half up
        rounded  = {1'b0, res_next[RW-1:1]} + {{OUT_BITS{1'b0}}, res_next[0]};
        x_load   = (XW'(1) << WORK_BITS) | (XW'(bus.in_frac) << (WORK_BITS - IN_BITS));
    end

    // Control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_log_r   <= '0;
            cnt         <= '0;
            x           <= '0;
            res         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        x          <= x_load;
                        cnt        <= '0;
                        res        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= S_ITER;
                    end
                end
                S_ITER: begin
                    x   <= x_next;
                    res <= res_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(OUT_BITS)) begin
                        // Rounding up from all ones would wrap to 0; clamp instead
                        out_log_r   <= rounded[OUT_BITS] ? '1 : rounded[OUT_BITS-1:0];
                        out_valid_r <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_log   = out_log_r;
endmodule

// File: tb/tb_log2_frac_iter.sv
// Self-checking bench for log2_frac_iter: directed vector table, hand-written
// handshake/reset sequences and a full input sweep against a reference model.
module tb_log2_frac_iter;
    localparam int IN_BITS   = 8;
    localparam int OUT_BITS  = 7;
    localparam int WORK_BITS = 16;
    localparam int LAT       = OUT_BITS + 1;
    localparam int II        = OUT_BITS + 3;

    logic clock;
    logic resetn;

    log2_frac_iter_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) bus ();

    log2_frac_iter #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS),
        .WORK_BITS(WORK_BITS)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests;
    int fails;

    typedef struct {
        logic [7:0] frac;
        int         stall;
        int         expect_log;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Bit-exact reference: square a fixed-point value and halve when it
    // reaches 2, collecting one log bit per step, then round half up.
    function automatic int model_log(input int f);
        longint x;
        longint s;
        int     r;
        x = longint'((1 << IN_BITS) + f) << (WORK_BITS - IN_BITS);
        r = 0;
        for (int i = 0; i < OUT_BITS + 1; i++) begin
            s = x * x;
            if (s >= (longint'(2) << (2 * WORK_BITS))) begin
                r = r * 2 + 1;
                x = s >> (WORK_BITS + 1);
            end else begin
                r = r * 2;
                x = s >> WORK_BITS;
            end
        end
        r = (r >> 1) + (r & 1);
        if (r > (1 << OUT_BITS) - 1) r = (1 << OUT_BITS) - 1;
        return r;
    endfunction

    function automatic int ideal_log(input int f);
        real v;
        v = $ln(1.0 + real'(f) / real'(1 << IN_BITS)) / $ln(2.0) * real'(1 << OUT_BITS);
        return int'($floor(v + 0.5));
    endfunction

    // One full transaction: accept, wait for result, hold off out_ready for
    // 'stall' cycles, then handshake. Returns the result and latency.
    task automatic do_op(input logic [7:0] f, input int stall, output int res, output int lat);
        int n;
        @(negedge clock);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 0, 1);
        bus.in_frac   = f;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (!bus.out_valid) check("in_ready_busy", int'(bus.in_ready), 0);
        end while (!bus.out_valid && lat < 40);
        if (lat >= 40) check("out_valid_timeout", 0, 1);
        check("in_ready_done", int'(bus.in_ready), 0);
        res = int'(bus.out_log);
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            check("stall_valid", int'(bus.out_valid), 1);
            check("stall_log", int'(bus.out_log), res);
        end
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1 bus.out_ready = 1'b0;
        @(negedge clock);
        check("post_hs_valid", int'(bus.out_valid), 0);
        check("post_hs_in_ready", int'(bus.in_ready), 1);
    endtask

    vec_t vecs[$];
    int   res;
    int   lat;
    int   prev;
    int   n;
    int   acc[$];

    initial begin
        tests         = 0;
        fails         = 0;
        resetn        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_frac   = '0;
        bus.out_ready = 1'b0;

        vecs.push_back('{8'h00, 0, 0});
        vecs.push_back('{8'h80, 20, 75});
        vecs.push_back('{8'hFF, 1, 127});
        vecs.push_back('{8'h40, 2, 41});
        vecs.push_back('{8'hC0, 0, 103});
        vecs.push_back('{8'h01, 3, 1});

        repeat (3) @(negedge clock);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_out_log", int'(bus.out_log), 0);
        check("reset_in_ready", int'(bus.in_ready), 1);
        resetn = 1'b1;

        // Directed vectors
        foreach (vecs[i]) begin
            do_op(vecs[i].frac, vecs[i].stall, res, lat);
            check($sformatf("vec_log_%02h", vecs[i].frac), res, vecs[i].expect_log);
            check($sformatf("vec_lat_%02h", vecs[i].frac), lat, LAT);
        end

        // Backpressure with a second request held during the busy period
        @(negedge clock);
        bus.in_frac  = 8'h80;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1 bus.in_frac = 8'h00;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.out_valid && n < 40);
        check("bp_log", int'(bus.out_log), 75);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("bp_valid", int'(bus.out_valid), 1);
            check("bp_hold", int'(bus.out_log), 75);
            check("bp_in_ready", int'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1 bus.out_ready = 1'b0;
        @(negedge clock);
        check("bp_in_ready_back", int'(bus.in_ready), 1);
        check("bp_valid_drop", int'(bus.out_valid), 0);
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        @(negedge clock);
        check("bp_second_accepted", int'(bus.in_ready), 0);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.out_valid && n < 40);
        check("bp_second_log", int'(bus.out_log), 0);
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1 bus.out_ready = 1'b0;

        // Back-to-back throughput with in_valid and out_ready held high
        @(negedge clock);
        bus.in_frac   = 8'h80;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clock);
            if (bus.in_ready) acc.push_back(i);
        end
        bus.in_valid = 1'b0;
        check("ii_accept_count", (acc.size() >= 3) ? 1 : 0, 1);
        for (int i = 1; i < acc.size(); i++)
            check("ii_interval", acc[i] - acc[i-1], II);
        n = 0;
        while (!bus.in_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        bus.out_ready = 1'b0;

        // Exhaustive sweep with random backpressure
        prev = 0;
        for (int f = 0; f < (1 << IN_BITS); f++) begin
            do_op(8'(f), int'($urandom_range(0, 3)), res, lat);
            check($sformatf("sweep_model_%0d", f), res, model_log(f));
            n = res - ideal_log(f);
            check($sformatf("sweep_ideal_%0d", f), (n >= -1 && n <= 1) ? 1 : 0, 1);
            check($sformatf("sweep_mono_%0d", f), (res >= prev) ? 1 : 0, 1);
            prev = res;
        end

        // Leave a nonzero result on out_log, then reset mid-iteration
        do_op(8'h80, 0, res, lat);
        check("pre_reset_log", res, 75);
        bus.in_frac  = 8'h80;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        check("midreset_valid", int'(bus.out_valid), 0);
        check("midreset_log", int'(bus.out_log), 0);
        check("midreset_in_ready", int'(bus.in_ready), 1);
        @(negedge clock);
        resetn = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (bus.out_valid) n++;
        end
        check("midreset_no_partial", n, 0);
        do_op(8'h00, 1, res, lat);
        check("after_reset_log", res, 0);
        check("after_reset_lat", lat, LAT);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/log2_frac_iter.md
Name: log2_frac_iter

Overview:
- Iterative linear-to-log fraction converter: the inverse of the Pow2 fraction LUT used in the log-domain datapath.
- Input is an unsigned significand fraction f, interpreted as 1 + f/2^IN_BITS.
- Output is the log2 fraction, rounded to nearest: approximately round(log2(1 + f/2^IN_BITS) * 2^OUT_BITS).
- Sits at the linear-to-log boundary, after accumulation and normalisation.
- Uses valid/ready handshakes on both sides and produces one result bit per cycle by repeated squaring.

Parameters:
IN_BITS, 8, input fraction width
OUT_BITS, 7, output log-fraction width
WORK_BITS, 16, fractional bits of the working register x (must be >= IN_BITS)

Ports:
clock  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
in_valid  in  1  input fraction valid
in_ready  out  1  block can accept an input
in_frac  in  IN_BITS  linear fraction f
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_log  out  OUT_BITS  rounded log2 fraction

Behaviour:
- Reset (async assert, sync release): state=IDLE, out_valid=0, out_log=0, bit counter=0, x=0, result shift register=0. in_ready=1 after reset.
- Reset mid-iteration or mid-DONE aborts the operation; no partial result is ever presented.
- State IDLE:
  - in_ready=1.
  - On in_valid at an edge: x <= {1, in_frac, zero pad to WORK_BITS frac}, counter <= 0, go to ITER.
- State ITER:
  - in_ready=0; in_valid is ignored (not consumed).
  - Each edge:
    - s = x*x, exact, 2*WORK_BITS frac, range [1,4).
    - If s >= 2: result bit = 1 and x <= s/2. Otherwise result bit = 0 and x <= s.
    - x is truncated to WORK_BITS frac.
    - The result bit shifts into the LSB of an (OUT_BITS+1)-bit result register.
    - counter increments.
  - After OUT_BITS+1 iterations (counter == OUT_BITS at that edge), the same edge does the following:
    - out_log <= upper OUT_BITS of the result + final round bit (round half up).
    - If that sum = 2^OUT_BITS, out_log saturates to all ones.
    - out_valid <= 1; go to DONE.
- State DONE:
  - out_valid=1; out_log is held stable while out_ready=0.
  - On out_ready at an edge: out_valid <= 0, go to IDLE. in_ready returns to 1 the following cycle.
  - in_ready=0 throughout DONE.
- Latency:
  - Accept edge t0 → out_valid high after edge t0+OUT_BITS+1 (t0+8 at defaults).
  - Minimum initiation interval is OUT_BITS+3 cycles (10 at defaults), when out_ready is held high.
- Arithmetic:
  - Multiplier is (WORK_BITS+1)x(WORK_BITS+1) unsigned.
  - The s >= 2 test is bit 2*WORK_BITS+1 of the product.
  - Results are bit-exact to this algorithm. The bench's golden model implements the identical truncation.
  - Accuracy vs ideal real-valued rounding: within 1 LSB for every input.
- in_frac=0 yields x=1 on every iteration, so all result bits are 0 and out_log=0.
- No X may propagate to out_log when out_valid=0 (it holds its last value).

Test Plan:
- Reset then in_frac=0x00, out_ready=1 → out_valid rises 8 cycles after accept, out_log=0x00; in_ready low throughout ITER and DONE.
- in_frac=0x80 (1.5) → result bits 1001010 with round bit 1, out_log=75 (ideal 74.87).
- in_frac=0xFF → out_log=127, no wrap to 0 (saturation path exercised if rounding overflows).
- Backpressure: in_frac=0x80 with out_ready=0 for 20 cycles → out_valid and out_log=75 stay stable. Raise out_ready → one-cycle handshake, then in_ready=1 the next cycle. A second in_valid held during the busy period is accepted only after that.
- Exhaustive sweep of in_frac 0..255, random out_ready → every result matches the bit-exact model and is within 1 LSB of round(log2(1+f/256)*128). Outputs are monotonic non-decreasing in f.
- Assert resetn low at iteration 4 of in_frac=0x80 → out_valid=0, out_log=0, state IDLE. After release, new in_frac=0x00 → out_log=0 with normal latency.
